pipeline_stall_sequencer: RTL

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Takes the raw

---
 rtl/pipeline_stall_sequencer_if.sv | 34 +++
 rtl/pipeline_stall_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipeline_stall_sequencer_if.sv
// Hazard/event inputs and pipeline stall controls between the hazard logic and the stall sequencer.
// StallCycles exists only when STALL_STATS_EN is defined.
interface pipeline_stall_sequencer_if;
   logic       LoadUseHazard;
   logic       BranchTaken;
   logic       MulDivStart;
   logic       MulDivDone;
   logic       PCWrite;
   logic       IFIDWrite;
   logic       IFIDFlush;
   logic       IDEXBubble;
   logic [1:0] State;
   logic       MulDivTimeout;
`ifdef STALL_STATS_EN
   logic [15:0] StallCycles;
`endif

   // master: event source / control consumer; slave: the sequencer
   modport master (
`ifdef STALL_STATS_EN
      input  StallCycles,
`endif
      output LoadUseHazard, BranchTaken, MulDivStart, MulDivDone,
      input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, State, MulDivTimeout
   );

   modport slave (
`ifdef STALL_STATS_EN
      output StallCycles,
`endif
      input  LoadUseHazard, BranchTaken, MulDivStart, MulDivDone,
      output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, State, MulDivTimeout
   );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline; Moore outputs, events affect outputs the cycle after sampling.
// Optional STALL_STATS_EN adds a saturating count of LOAD/MDWAIT cycles.
module pipeline_stall_sequencer #(
   parameter int LOAD_STALL_CYCLES   = 1,
   parameter int BRANCH_FLUSH_CYCLES = 1,
   parameter int MULDIV_TIMEOUT      = 32,
   parameter int CNT_W               = 6
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   pipeline_stall_sequencer_if.slave    io_seq
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_MDWAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] MD_LAST      = CNT_W'(MULDIV_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timeout_set;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_RUN;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= r_timeout | w_timeout_set;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_timeout_set = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (io_seq.BranchTaken) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = FLUSH_RELOAD;
            end else if (io_seq.MulDivStart) begin
               w_state_nxt = ST_MDWAIT;
               w_cnt_nxt   = '0;
            end else if (io_seq.LoadUseHazard) begin
               w_state_nxt = ST_LOAD;
               w_cnt_nxt   = LOAD_RELOAD;
            end
         end
         ST_LOAD: begin
            // A taken branch squashes the stalled instruction, so the flush wins.
            if (io_seq.BranchTaken) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = FLUSH_RELOAD;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         ST_FLUSH: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         ST_MDWAIT: begin
            if (io_seq.MulDivDone) begin
               w_state_nxt = ST_RUN;
            end else if (r_cnt == MD_LAST) begin
               w_state_nxt   = ST_RUN;
               w_timeout_set = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign io_seq.PCWrite       = (r_state == ST_RUN) || (r_state == ST_FLUSH);
   assign io_seq.IFIDWrite     = (r_state == ST_RUN) || (r_state == ST_FLUSH);
   assign io_seq.IFIDFlush     = (r_state == ST_FLUSH);
   assign io_seq.IDEXBubble    = (r_state != ST_RUN);
   assign io_seq.State         = r_state;
   assign io_seq.MulDivTimeout = r_timeout;

`ifdef STALL_STATS_EN
   logic [15:0] r_stall_cycles;
   logic        w_stalled;

   assign w_stalled = (r_state == ST_LOAD) || (r_state == ST_MDWAIT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cycles <= '0;
      end else if (w_stalled && (r_stall_cycles != 16'hFFFF)) begin
         r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign io_seq.StallCycles = r_stall_cycles;
`endif

endmodule
